// File: rtl/bus_cycle_monitor_pkg.sv
// Shared definitions for the bus cycle monitor: FSM state encoding,
// acknowledge port-size codes and the decode of the acknowledge strobes.
package bus_cycle_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_BYTE = 2'b01;
  localparam logic [1:0] ACK_WORD = 2'b10;
  localparam logic [1:0] ACK_LONG = 2'b11;

  localparam int CNT_W = 8;

  // Strobes are active-low; a synchronous termination always means a long-word port.
  function automatic logic [1:0] ack_code(input logic dsack0_n,
                                          input logic dsack1_n,
                                          input logic sterm_n);
    logic [1:0] code;
    code = ACK_NONE;
    if (!sterm_n || (!dsack0_n && !dsack1_n)) begin
      code = ACK_LONG;
    end else if (!dsack1_n) begin
      code = ACK_WORD;
    end else if (!dsack0_n) begin
      code = ACK_BYTE;
    end
    return code;
  endfunction

endpackage

// File: rtl/bus_cycle_monitor_sync_ff.sv
// Multi-stage synchroniser for one asynchronous active-low strobe.
// Resets to 1 so that a freshly reset chain reads as "strobe negated".
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      stage_q <= '1;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bus_cycle_monitor.sv
// Watches an asynchronous bus: synchronises the strobes, tracks each address
// strobe cycle through acknowledge or timeout, and reports when the bus is idle.
module bus_cycle_monitor
  import bus_cycle_monitor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS_,
  input  logic       DSACK0_,
  input  logic       DSACK1_,
  input  logic       STERM_,
  input  logic       BG_,
  input  logic       DREQ_,
  output logic       DSACK0_S,
  output logic       DSACK1_S,
  output logic       STERM_S,
  output logic       BGRANT_,
  output logic       DREQ_S,
  output logic       CYCLEDONE,
  output logic [1:0] ACK_SIZE,
  output logic       TIMEOUT
);

  localparam int N_IN   = 6;
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [WARM_W-1:0] WARM_DONE    = WARM_W'(SYNC_STAGES);

  logic [N_IN-1:0] async_in;
  logic [N_IN-1:0] sync_out;

  assign async_in = {DREQ_, BG_, STERM_, DSACK1_, DSACK0_, AS_};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_sync
      sync_ff #(
        .DEPTH(SYNC_STAGES)
      ) u_sync (
        .clk_i (CLK),
        .srst_i(RST),
        .d_i   (async_in[gi]),
        .q_o   (sync_out[gi])
      );
    end
  endgenerate

  logic as_s;
  assign as_s     = sync_out[0];
  assign DSACK0_S = sync_out[1];
  assign DSACK1_S = sync_out[2];
  assign STERM_S  = sync_out[3];
  assign BGRANT_  = sync_out[4];
  assign DREQ_S   = sync_out[5];

  // The chains reset to 1, which only mimics an idle bus; real input samples
  // have reached the outputs once SYNC_STAGES clocks have passed since reset.
  logic [WARM_W-1:0] warm_q;
  logic              warm_done;

  assign warm_done = (warm_q == WARM_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      warm_q <= '0;
    end else if (!warm_done) begin
      warm_q <= warm_q + 1'b1;
    end
  end

  logic ack_seen;
  logic bus_quiet;

  assign ack_seen  = !DSACK0_S || !DSACK1_S || !STERM_S;
  assign bus_quiet = as_s && DSACK0_S && DSACK1_S && STERM_S;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ack_size_q, ack_size_d;
  logic             timeout_q, timeout_d;
  logic             cycledone_q, cycledone_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_size_q  <= ACK_NONE;
      timeout_q   <= 1'b0;
      cycledone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_size_q  <= ack_size_d;
      timeout_q   <= timeout_d;
      cycledone_q <= cycledone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_size_d  = ack_size_q;
    timeout_d   = 1'b0;
    cycledone_d = (state_q == IDLE) && bus_quiet && warm_done;

    case (state_q)
      IDLE: begin
        if (!as_s) begin
          state_d    = WAIT_ACK;
          cnt_d      = '0;
          ack_size_d = ACK_NONE;
        end
      end

      WAIT_ACK: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Acknowledge beats both abort and timeout when they coincide.
        if (ack_seen) begin
          ack_size_d = ack_code(DSACK0_S, DSACK1_S, STERM_S);
          state_d    = WAIT_REL;
        end else if (as_s) begin
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d  = 1'b1;
          ack_size_d = ACK_NONE;
          state_d    = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (bus_quiet) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign CYCLEDONE = cycledone_q;
  assign ACK_SIZE  = ack_size_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_bus_cycle_monitor.sv
// Randomised check of bus_cycle_monitor against a transaction-level model:
// expected outputs are derived from step numbers of each bus cycle.
module tb_bus_cycle_monitor;

  localparam int S  = 2;
  localparam int TO = 200;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       AS_ = 1'b1, DSACK0_ = 1'b1, DSACK1_ = 1'b1, STERM_ = 1'b1;
  logic       BG_ = 1'b1, DREQ_ = 1'b1;
  logic       DSACK0_S, DSACK1_S, STERM_S, BGRANT_, DREQ_S;
  logic       CYCLEDONE, TIMEOUT;
  logic [1:0] ACK_SIZE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] pipe_q[$];
  logic [4:0] exp_sync;
  logic [1:0] ack_prev = 2'b00;

  bus_cycle_monitor #(
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .AS_      (AS_),
    .DSACK0_  (DSACK0_),
    .DSACK1_  (DSACK1_),
    .STERM_   (STERM_),
    .BG_      (BG_),
    .DREQ_    (DREQ_),
    .DSACK0_S (DSACK0_S),
    .DSACK1_S (DSACK1_S),
    .STERM_S  (STERM_S),
    .BGRANT_  (BGRANT_),
    .DREQ_S   (DREQ_S),
    .CYCLEDONE(CYCLEDONE),
    .ACK_SIZE (ACK_SIZE),
    .TIMEOUT  (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the synchronised outputs are modelled as a plain delay line.
  task automatic tick();
    logic [4:0] cur;
    logic       rst_now;
    cur     = {DREQ_, BG_, STERM_, DSACK1_, DSACK0_};
    rst_now = RST;
    @(posedge CLK);
    #1;
    if (rst_now) begin
      pipe_q.delete();
      for (int k = 0; k < S - 1; k++) pipe_q.push_back(5'h1f);
      exp_sync = 5'h1f;
    end else begin
      pipe_q.push_back(cur);
      exp_sync = pipe_q.pop_front();
    end
    chk("sync_out", {3'b000, DREQ_S, BGRANT_, STERM_S, DSACK1_S, DSACK0_S}, {3'b000, exp_sync});
  endtask

  function automatic logic [1:0] size_of(input logic [2:0] mask);
    // mask bits: [2] STERM_ low, [1] DSACK1_ low, [0] DSACK0_ low
    case (mask)
      3'b001:  return 2'b01;
      3'b010:  return 2'b10;
      3'b011:  return 2'b11;
      default: return 2'b11;
    endcase
  endfunction

  // One bus cycle: AS_ low on steps 0..fin-1, acknowledge (if a>=1) on steps a..fin-1.
  task automatic run_txn(input string tag, input int a, input int fin, input logic [2:0] mask);
    logic       ack_valid, to_occurs;
    logic [1:0] code, exp_ack;
    int         e, n;
    code      = size_of(mask);
    ack_valid = (a >= 1) && (a <= TO) && (a < fin);
    to_occurs = !ack_valid && (fin > TO);
    n         = fin + S + 3;
    for (int j = 0; j < n; j++) begin
      AS_ = (j < fin) ? 1'b0 : 1'b1;
      if (a >= 1 && j >= a && j < fin) {STERM_, DSACK1_, DSACK0_} = ~mask;
      else {STERM_, DSACK1_, DSACK0_} = 3'b111;
      BG_   = 1'($urandom_range(0, 1));
      DREQ_ = 1'($urandom_range(0, 1));
      tick();
      e = j + 1;
      chk({tag, ".cycledone"}, {7'd0, CYCLEDONE}, {7'd0, (e <= S) || (e >= fin + S + 2)});
      chk({tag, ".timeout"}, {7'd0, TIMEOUT}, {7'd0, to_occurs && (e == S + 1 + TO)});
      if (e < S + 1) exp_ack = ack_prev;
      else if (ack_valid && e >= a + S + 1) exp_ack = code;
      else exp_ack = 2'b00;
      chk({tag, ".ack_size"}, {6'd0, ACK_SIZE}, {6'd0, exp_ack});
    end
    ack_prev = ack_valid ? code : 2'b00;
    $display("txn %s: ack_step=%0d release_step=%0d mask=%03b ack_size=%02b timeout_expected=%0b",
             tag, a, fin, mask, ack_prev, to_occurs);
  endtask

  task automatic reset_and_settle(input string tag);
    RST = 1'b1;
    {AS_, DSACK0_, DSACK1_, STERM_, BG_, DREQ_} = 6'h3f;
    tick();
    chk({tag, ".rst_cycledone"}, {7'd0, CYCLEDONE}, 8'd0);
    chk({tag, ".rst_ack_size"}, {6'd0, ACK_SIZE}, 8'd0);
    chk({tag, ".rst_timeout"}, {7'd0, TIMEOUT}, 8'd0);
    RST = 1'b0;
    for (int e = 1; e <= S + 3; e++) begin
      tick();
      chk({tag, ".cycledone"}, {7'd0, CYCLEDONE}, {7'd0, e >= S + 1});
      chk({tag, ".ack_size"}, {6'd0, ACK_SIZE}, 8'd0);
      chk({tag, ".timeout"}, {7'd0, TIMEOUT}, 8'd0);
    end
    ack_prev = 2'b00;
    $display("txn %s: reset released, bus idle", tag);
  endtask

  // Reset lands while the cycle counter holds 50 (WAIT_ACK step 51).
  task automatic mid_cycle_reset();
    for (int j = 0; j <= S + 50; j++) begin
      AS_ = 1'b0;
      {STERM_, DSACK1_, DSACK0_} = 3'b111;
      BG_   = 1'($urandom_range(0, 1));
      DREQ_ = 1'($urandom_range(0, 1));
      tick();
      chk("midrst.pre_timeout", {7'd0, TIMEOUT}, 8'd0);
      chk("midrst.pre_cycledone", {7'd0, CYCLEDONE}, {7'd0, (j + 1) <= S});
    end
    RST = 1'b1;
    {AS_, DSACK0_, DSACK1_, STERM_, BG_, DREQ_} = 6'h3f;
    tick();
    chk("midrst.cycledone", {7'd0, CYCLEDONE}, 8'd0);
    chk("midrst.ack_size", {6'd0, ACK_SIZE}, 8'd0);
    chk("midrst.timeout", {7'd0, TIMEOUT}, 8'd0);
    RST = 1'b0;
    for (int e = 1; e <= TO + 60; e++) begin
      tick();
      chk("midrst.post_timeout", {7'd0, TIMEOUT}, 8'd0);
      chk("midrst.post_cycledone", {7'd0, CYCLEDONE}, {7'd0, e >= S + 1});
      chk("midrst.post_ack_size", {6'd0, ACK_SIZE}, 8'd0);
    end
    ack_prev = 2'b00;
    $display("txn mid_cycle_reset: cycle abandoned at count 50");
  endtask

  initial begin
    int a, fin;
    logic [2:0] mask;

    reset_and_settle("reset_release");
    run_txn("word_ack", 5, 8, 3'b010);
    run_txn("timeout", 0, TO + 10, 3'b001);
    run_txn("sterm_at_limit", TO, TO + 3, 3'b100);
    run_txn("abort", 0, 4, 3'b001);
    run_txn("ack_after_timeout", TO + 1, TO + 5, 3'b011);
    run_txn("ack_one_before_limit", TO - 1, TO + 2, 3'b001);

    for (int t = 0; t < 24; t++) begin
      mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) begin
        run_txn("rand_abort", 0, int'($urandom_range(1, 20)), mask);
      end else begin
        a   = int'($urandom_range(1, 25));
        fin = a + int'($urandom_range(1, 6));
        run_txn("rand_ack", a, fin, mask);
      end
    end

    mid_cycle_reset();
    run_txn("after_reset_byte", 3, 6, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bus_cycle_monitor.md
BUS_CYCLE_MONITOR -- requirements
Module: bus_cycle_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for every asynchronous bus input, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200: acknowledge timeout in CLK cycles, range 2..255.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port AS_, input, 1 bit: asynchronous bus address strobe, active-low.
REQ-006 SHALL have ports DSACK0_, DSACK1_, STERM_, BG_, DREQ_, input, 1 bit each: asynchronous bus/peripheral strobes, active-low.
REQ-007 SHALL have ports DSACK0_S, DSACK1_S, STERM_S, BGRANT_, DREQ_S, output, 1 bit each: synchronised copies of the inputs in REQ-006; BGRANT_ is the synchronised BG_.
REQ-008 SHALL have port CYCLEDONE, output, 1 bit: previous bus cycle fully terminated and bus idle.
REQ-009 SHALL have port ACK_SIZE, output, 2 bits: port size of last acknowledge (00 none, 01 byte, 10 word, 11 long).
REQ-010 SHALL have port TIMEOUT, output, 1 bit: one-cycle pulse when no acknowledge arrives in time.

Function
REQ-011 Each input in REQ-005/006 SHALL pass through a SYNC_STAGES-deep flop chain; output follows input change after exactly SYNC_STAGES rising edges.
REQ-012 FSM states SHALL be IDLE, WAIT_ACK, WAIT_REL.
REQ-013 IDLE -> WAIT_ACK when synchronised AS_ is 0; cycle counter cleared and ACK_SIZE cleared to 00 on that transition.
REQ-014 In WAIT_ACK, counter SHALL increment by 1 per cycle; saturating 8-bit, no wrap.
REQ-015 In WAIT_ACK, any of DSACK0_S/DSACK1_S/STERM_S at 0 SHALL latch ACK_SIZE (STERM_S=0 or both DSACK=0 -> 11; DSACK1_S only -> 10; DSACK0_S only -> 01) and go to WAIT_REL.
REQ-016 In WAIT_ACK with no acknowledge and counter == TIMEOUT_CYCLES-1, TIMEOUT SHALL pulse high exactly one cycle and FSM go to WAIT_REL with ACK_SIZE 00.
REQ-017 Acknowledge and timeout in the same cycle: acknowledge wins, TIMEOUT stays 0.
REQ-018 In WAIT_ACK, synchronised AS_ returning to 1 with no acknowledge (aborted cycle) SHALL return to IDLE without TIMEOUT.
REQ-019 WAIT_REL -> IDLE when synchronised AS_, DSACK0_S, DSACK1_S, STERM_S all 1.
REQ-020 CYCLEDONE SHALL be registered: set one cycle after a cycle in which FSM is IDLE and synchronised AS_, DSACK0_S, DSACK1_S, STERM_S are all 1; cleared otherwise.
REQ-021 ACK_SIZE SHALL hold its value from latch until next IDLE -> WAIT_ACK transition.
REQ-022 BGRANT_ and DREQ_S SHALL not influence the FSM.

Reset
REQ-023 While RST=1 at a rising edge: all synchroniser flops -> 1, FSM -> IDLE, counter -> 0, ACK_SIZE -> 00, TIMEOUT -> 0, CYCLEDONE -> 0.
REQ-024 Reset asserted mid-cycle (WAIT_ACK or WAIT_REL) SHALL abandon the cycle with no TIMEOUT pulse; after release CYCLEDONE rises no earlier than SYNC_STAGES+1 cycles.

Structure
REQ-025 Shared package SHALL hold the FSM state enumeration and the ACK_SIZE code constants (none/byte/word/long).
REQ-026 A single sub-module sync_ff (parameterised depth, reset value 1) SHALL implement REQ-011 and be instantiated once per input.

Verification
REQ-027 Reset release, all inputs 1 -> CYCLEDONE=1 at cycle SYNC_STAGES+1 (3 with defaults), ACK_SIZE=00, TIMEOUT=0.
REQ-028 AS_=0, DSACK1_=0 after 5 cycles, both released after 3 cycles -> ACK_SIZE=10, CYCLEDONE low during cycle, high again 1 cycle after IDLE re-entry.
REQ-029 AS_=0, no acknowledge, TIMEOUT_CYCLES=200 -> TIMEOUT single pulse 200 cycles after WAIT_ACK entry, ACK_SIZE=00, FSM WAIT_REL until AS_=1.
REQ-030 STERM_=0 arriving on the same cycle counter reaches 199 -> ACK_SIZE=11, no TIMEOUT.
REQ-031 AS_ 0 for 4 cycles then 1, no acknowledge -> FSM returns IDLE, no TIMEOUT, ACK_SIZE=00.
REQ-032 RST=1 while in WAIT_ACK at count 50 -> all outputs at reset values next edge, no TIMEOUT afterwards.
